// File: rtl/imu_bracket_feeder.sv
// Buffers a timestamped IMU sample stream and, for each query time, emits the
// adjacent sample pair that brackets it in the interpolator's input format.
// Pair pulse j+2 cycles after query accept (match at offset j); stale/timeout pulses are 1 cycle.
module imu_bracket_feeder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [127:0]             s_data,
  input  logic                     q_valid,
  output logic                     q_ready,
  input  logic [63:0]              q_time,
  output logic [127:0]             data_out,
  output logic [127:0]             prev_out,
  output logic [63:0]              target_out,
  output logic                     pair_valid,
  output logic                     q_stale,
  output logic                     q_timeout,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [127:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_oldest;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_drop;
  logic [63:0]     r_target;
  logic [AW-1:0]   r_k, w_k_nxt;
  logic [TW-1:0]   r_wait, w_wait_nxt;
  logic            r_hit;
  logic [127:0]    r_hit_prev, r_hit_data;
  logic [127:0]    r_data_out, r_prev_out;
  logic [63:0]     r_target_out;
  logic            r_pair_valid, r_stale, r_timeout;

  logic            w_full, w_s_fire, w_mono, w_wr_en, w_drop;
  logic [AW-1:0]   w_newest_idx, w_wr_idx, w_idx_a, w_idx_b;
  logic [63:0]     w_newest_ts, w_ts_a, w_ts_b;
  logic            w_hit, w_stale, w_timeout, w_latch_q;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_newest_idx = r_oldest + AW'(r_count - CW'(1));
  assign w_wr_idx     = r_oldest + r_count[AW-1:0];
  assign w_newest_ts  = r_mem[w_newest_idx][63:0];
  assign w_idx_a      = r_oldest + r_k;
  assign w_idx_b      = w_idx_a + AW'(1);
  assign w_ts_a       = r_mem[w_idx_a][63:0];
  assign w_ts_b       = r_mem[w_idx_b][63:0];

  // Never overwrite the oldest entry while a scan may be reading it.
  assign s_ready  = !rst && !(w_full && (r_state == ST_SEARCH));
  assign q_ready  = !rst && (r_state == ST_IDLE);
  assign w_s_fire = s_valid && s_ready;
  // Only strictly increasing timestamps enter the history.
  assign w_mono   = (r_count == '0) || (s_data[63:0] > w_newest_ts);
  assign w_wr_en  = w_s_fire && w_mono;
  assign w_drop   = w_s_fire && !w_mono;

  assign data_out   = r_data_out;
  assign prev_out   = r_prev_out;
  assign target_out = r_target_out;
  assign pair_valid = r_pair_valid;
  assign q_stale    = r_stale;
  assign q_timeout  = r_timeout;
  assign drop_cnt   = r_drop;
  assign count      = r_count;

  // Sample storage; contents need no reset since r_count marks validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= s_data;
  end

  // Circular buffer occupancy and drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oldest <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_wr_en) begin
        if (w_full) r_oldest <= r_oldest + AW'(1);
        else        r_count  <= r_count + CW'(1);
      end
      if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

  // Query FSM: next state, scan offset, wait counter and result strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_wait_nxt  = r_wait;
    w_hit       = 1'b0;
    w_stale     = 1'b0;
    w_timeout   = 1'b0;
    w_latch_q   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (q_valid) begin
          w_latch_q   = 1'b1;
          w_k_nxt     = '0;
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (r_count < CW'(2)) begin
          w_wait_nxt  = '0;
          w_state_nxt = ST_WAIT;
        end else if ((r_k == '0) && (r_target < w_ts_a)) begin
          w_stale     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if ((w_ts_a <= r_target) && (r_target <= w_ts_b)) begin
          w_hit       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (({1'b0, r_k} + CW'(1)) == (r_count - CW'(1))) begin
          w_wait_nxt  = '0;
          w_state_nxt = ST_WAIT;
        end else begin
          w_k_nxt = r_k + AW'(1);
        end
      end
      ST_WAIT: begin
        if (w_wr_en) begin
          // Only the newest pair can bracket a target beyond the old newest.
          w_k_nxt     = w_full ? AW'(DEPTH - 2) : AW'(r_count - CW'(1));
          w_state_nxt = ST_SEARCH;
        end else if (r_wait == TW'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_wait_nxt = r_wait + TW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and query registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_wait   <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_wait  <= w_wait_nxt;
      if (w_latch_q) r_target <= q_time;
    end
  end

  // Capture the matched pair immediately so later overwrites cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit      <= 1'b0;
      r_hit_prev <= '0;
      r_hit_data <= '0;
    end else begin
      r_hit <= w_hit;
      if (w_hit) begin
        r_hit_prev <= r_mem[w_idx_a];
        r_hit_data <= r_mem[w_idx_b];
      end
    end
  end

  // Output stage: pulses plus held pair/target values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair_valid <= 1'b0;
      r_stale      <= 1'b0;
      r_timeout    <= 1'b0;
      r_data_out   <= '0;
      r_prev_out   <= '0;
      r_target_out <= '0;
    end else begin
      r_pair_valid <= r_hit;
      r_stale      <= w_stale;
      r_timeout    <= w_timeout;
      if (r_hit) begin
        r_data_out   <= r_hit_data;
        r_prev_out   <= r_hit_prev;
        r_target_out <= r_target;
      end
    end
  end

endmodule

// File: tb/tb_imu_bracket_feeder.sv
// Directed bench for imu_bracket_feeder: pairing, stale, wait/write, timeout,
// overwrite/drop and reset-during-search scenarios with cycle-exact checks.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_imu_bracket_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         q_valid;
  logic         q_ready;
  logic [63:0]  q_time;
  logic [127:0] data_out;
  logic [127:0] prev_out;
  logic [63:0]  target_out;
  logic         pair_valid;
  logic         q_stale;
  logic         q_timeout;
  logic [15:0]  drop_cnt;
  logic [3:0]   count;

  int n_checks = 0;
  int n_pass   = 0;

  imu_bracket_feeder #(.DEPTH(8), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .q_valid(q_valid), .q_ready(q_ready), .q_time(q_time),
    .data_out(data_out), .prev_out(prev_out), .target_out(target_out),
    .pair_valid(pair_valid), .q_stale(q_stale), .q_timeout(q_timeout),
    .drop_cnt(drop_cnt), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [63:0] ts);
    return {ts ^ 64'h1111_2222_3333_4444, ts};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_sample(input logic [63:0] ts);
    s_valid = 1'b1; s_data = mk(ts);
    step();
    s_valid = 1'b0;
  endtask

  task automatic issue_query(input logic [63:0] t);
    q_valid = 1'b1; q_time = t;
    step();
    q_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; q_valid = 1'b0; q_time = '0;
    #2;
    n_checks++; if ({pair_valid, q_stale, q_timeout} !== 3'b000) $display("FAIL reset_pulses got %b exp 000", {pair_valid, q_stale, q_timeout}); else n_pass++;
    n_checks++; if (data_out !== 128'd0 || prev_out !== 128'd0 || target_out !== 64'd0) $display("FAIL reset_data got %h/%h/%h exp 0", data_out, prev_out, target_out); else n_pass++;
    n_checks++; if (count !== 4'd0 || drop_cnt !== 16'd0) $display("FAIL reset_counts got %0d/%0d exp 0/0", count, drop_cnt); else n_pass++;
    n_checks++; if ({s_ready, q_ready} !== 2'b00) $display("FAIL reset_ready_in_rst got %b exp 00", {s_ready, q_ready}); else n_pass++;
    step(); step(); rst = 1'b0; #1;
    n_checks++; if ({s_ready, q_ready} !== 2'b11) $display("FAIL reset_ready_after got %b exp 11", {s_ready, q_ready}); else n_pass++;
  endtask

  task automatic test_pair_basic();
    write_sample(64'd100); write_sample(64'd200); write_sample(64'd300);
    n_checks++; if (count !== 4'd3) $display("FAIL basic_count got %0d exp 3", count); else n_pass++;
    issue_query(64'd250);
    step();
    n_checks++; if ({pair_valid, q_ready} !== 2'b00) $display("FAIL basic_c1 got pv/qr %b exp 00", {pair_valid, q_ready}); else n_pass++;
    step();
    n_checks++; if ({pair_valid, q_ready} !== 2'b01) $display("FAIL basic_c2 got pv/qr %b exp 01", {pair_valid, q_ready}); else n_pass++;
    step();
    n_checks++; if (pair_valid !== 1'b1) $display("FAIL basic_pv_c3 got %b exp 1", pair_valid); else n_pass++;
    n_checks++; if (prev_out !== mk(64'd200) || data_out !== mk(64'd300)) $display("FAIL basic_pair got %h/%h exp %h/%h", prev_out, data_out, mk(64'd200), mk(64'd300)); else n_pass++;
    n_checks++; if (target_out !== 64'd250) $display("FAIL basic_target got %0d exp 250", target_out); else n_pass++;
    step();
    n_checks++; if (pair_valid !== 1'b0 || data_out !== mk(64'd300)) $display("FAIL basic_hold got pv %b data %h exp 0/%h", pair_valid, data_out, mk(64'd300)); else n_pass++;
  endtask

  task automatic test_stale();
    issue_query(64'd50);
    step();
    n_checks++; if ({q_stale, pair_valid, q_timeout} !== 3'b100) $display("FAIL stale_pulse got %b exp 100", {q_stale, pair_valid, q_timeout}); else n_pass++;
    n_checks++; if (q_ready !== 1'b1) $display("FAIL stale_qready got %b exp 1", q_ready); else n_pass++;
    step();
    n_checks++; if ({q_stale, pair_valid} !== 2'b00) $display("FAIL stale_end got %b exp 00", {q_stale, pair_valid}); else n_pass++;
  endtask

  task automatic test_wait_write();
    int n;
    bit seen;
    issue_query(64'd400);
    repeat (10) step();
    n_checks++; if ({q_ready, pair_valid, q_timeout} !== 3'b000) $display("FAIL wait_waiting got %b exp 000", {q_ready, pair_valid, q_timeout}); else n_pass++;
    write_sample(64'd450);
    seen = 1'b0; n = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      step();
      if (pair_valid === 1'b1) begin seen = 1'b1; n = i; end
    end
    n_checks++; if (!seen || n != 2) $display("FAIL wait_pair_latency got seen %0d after %0d exp 1 after 2", seen, n); else n_pass++;
    n_checks++; if (prev_out !== mk(64'd300) || data_out !== mk(64'd450) || target_out !== 64'd400) $display("FAIL wait_pair got %h/%h/%0d exp %h/%h/400", prev_out, data_out, target_out, mk(64'd300), mk(64'd450)); else n_pass++;
    n_checks++; if (count !== 4'd4) $display("FAIL wait_count got %0d exp 4", count); else n_pass++;
  endtask

  task automatic test_timeout();
    bit early;
    issue_query(64'd500);
    early = 1'b0;
    for (int i = 1; i <= 1026; i++) begin
      step();
      if (q_timeout === 1'b1 || pair_valid === 1'b1 || q_stale === 1'b1) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) $display("FAIL timeout_early got %b exp 0", early); else n_pass++;
    step();
    n_checks++; if ({q_timeout, pair_valid, q_stale} !== 3'b100) $display("FAIL timeout_pulse got %b exp 100", {q_timeout, pair_valid, q_stale}); else n_pass++;
    n_checks++; if (q_ready !== 1'b1) $display("FAIL timeout_qready got %b exp 1", q_ready); else n_pass++;
    step();
    n_checks++; if (q_timeout !== 1'b0) $display("FAIL timeout_end got %b exp 0", q_timeout); else n_pass++;
  endtask

  task automatic test_overwrite_drop();
    do_reset();
    for (int t = 100; t <= 900; t += 100) write_sample(64'(t));
    n_checks++; if (count !== 4'd8) $display("FAIL full_count got %0d exp 8", count); else n_pass++;
    issue_query(64'd150);
    step();
    n_checks++; if (q_stale !== 1'b1) $display("FAIL full_oldest_stale got %b exp 1", q_stale); else n_pass++;
    issue_query(64'd850);
    n_checks++; if (s_ready !== 1'b0) $display("FAIL full_sready_search got %b exp 0", s_ready); else n_pass++;
    repeat (7) step();
    n_checks++; if (pair_valid !== 1'b0) $display("FAIL full_pv_c7 got %b exp 0", pair_valid); else n_pass++;
    step();
    n_checks++; if (pair_valid !== 1'b1 || prev_out !== mk(64'd800) || data_out !== mk(64'd900)) $display("FAIL full_pair_c8 got pv %b %h/%h exp 1 %h/%h", pair_valid, prev_out, data_out, mk(64'd800), mk(64'd900)); else n_pass++;
    n_checks++; if (s_ready !== 1'b1) $display("FAIL full_sready_idle got %b exp 1", s_ready); else n_pass++;
    write_sample(64'd850);
    n_checks++; if (drop_cnt !== 16'd1 || count !== 4'd8) $display("FAIL drop_850 got drop %0d count %0d exp 1/8", drop_cnt, count); else n_pass++;
    write_sample(64'd900);
    n_checks++; if (drop_cnt !== 16'd2) $display("FAIL drop_equal got %0d exp 2", drop_cnt); else n_pass++;
  endtask

  task automatic test_lowest_k_and_rst();
    bit bad;
    do_reset();
    write_sample(64'd100); write_sample(64'd200); write_sample(64'd300);
    issue_query(64'd200);
    step(); step();
    n_checks++; if (pair_valid !== 1'b1 || prev_out !== mk(64'd100) || data_out !== mk(64'd200)) $display("FAIL lowk_pair got pv %b %h/%h exp 1 %h/%h", pair_valid, prev_out, data_out, mk(64'd100), mk(64'd200)); else n_pass++;
    issue_query(64'd250);
    rst = 1'b1; #1;
    n_checks++; if (data_out !== 128'd0 || prev_out !== 128'd0 || target_out !== 64'd0 || pair_valid !== 1'b0) $display("FAIL rst_outputs got %h/%h/%0d pv %b exp zeros", data_out, prev_out, target_out, pair_valid); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("FAIL rst_count got %0d exp 0", count); else n_pass++;
    step(); step();
    rst = 1'b0; #1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (pair_valid !== 1'b0 || q_stale !== 1'b0 || q_timeout !== 1'b0 || q_ready !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL rst_no_pulses got %b exp 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pair_basic();
    test_stale();
    test_wait_write();
    test_timeout();
    test_overwrite_drop();
    test_lowest_k_and_rst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
